// File: rtl/memory_access.sv
// EX/MEM pipeline register with a two-state data-memory handshake.
// Holds the captured instruction while the memory access is outstanding and bounds the wait with a timeout.
module memory_access #(
  parameter int unsigned MAX_WAIT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] ALUres,
  input  logic [31:0] writeData,
  input  logic [4:0]  rd,
  input  logic        regWrite,
  input  logic        memToReg,
  input  logic        memRead,
  input  logic        memWrite,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [31:0] ALUres_out,
  output logic [31:0] readData_out,
  output logic [4:0]  rd_out,
  output logic        regWrite_out,
  output logic        memToReg_out,
  output logic        stall,
  output logic        memErr
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  // The timeout fires on the edge that ends the MAX_WAIT-th BUSY cycle without an ack.
  localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] alu_q, alu_d;
  logic [31:0] wdata_q, wdata_d;
  logic [4:0]  rd_q, rd_d;
  logic        regwrite_q, regwrite_d;
  logic        memtoreg_q, memtoreg_d;
  logic        memread_q, memread_d;
  logic        memwrite_q, memwrite_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic        is_mem_s;
  logic        aligned_s;

  // Classify the instruction arriving from EX.
  always_comb begin
    is_mem_s  = memRead | memWrite;
    aligned_s = (ALUres[1:0] == 2'b00);
  end

  // Next-state logic: capture in IDLE, wait for ack or timeout in BUSY.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    alu_d      = alu_q;
    wdata_d    = wdata_q;
    rd_d       = rd_q;
    regwrite_d = regwrite_q;
    memtoreg_d = memtoreg_q;
    memread_d  = memread_q;
    memwrite_d = memwrite_q;
    rdata_d    = rdata_q;
    err_d      = err_q;

    case (state_q)
      IDLE: begin
        alu_d      = ALUres;
        wdata_d    = writeData;
        rd_d       = rd;
        regwrite_d = regWrite;
        memtoreg_d = memToReg;
        memread_d  = memRead;
        memwrite_d = memWrite;
        rdata_d    = 32'd0;
        cnt_d      = 8'd0;
        err_d      = 1'b0;
        if (is_mem_s) begin
          if (aligned_s) begin
            state_d = BUSY;
          end else begin
            err_d   = 1'b1;
            state_d = IDLE;
          end
        end else begin
          state_d = IDLE;
        end
      end
      BUSY: begin
        // An ack in the final allowed cycle still completes the access.
        if (mem_ack) begin
          state_d = IDLE;
          cnt_d   = 8'd0;
          rdata_d = memwrite_q ? 32'd0 : mem_rdata;
        end else if (cnt_q == WAIT_LAST) begin
          state_d = IDLE;
          cnt_d   = 8'd0;
          rdata_d = 32'd0;
          err_d   = 1'b1;
        end else begin
          state_d = BUSY;
          cnt_d   = cnt_q + 8'd1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 8'd0;
      end
    endcase
  end

  // State and pipeline registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= 8'd0;
      alu_q      <= 32'd0;
      wdata_q    <= 32'd0;
      rd_q       <= 5'd0;
      regwrite_q <= 1'b0;
      memtoreg_q <= 1'b0;
      memread_q  <= 1'b0;
      memwrite_q <= 1'b0;
      rdata_q    <= 32'd0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      alu_q      <= alu_d;
      wdata_q    <= wdata_d;
      rd_q       <= rd_d;
      regwrite_q <= regwrite_d;
      memtoreg_q <= memtoreg_d;
      memread_q  <= memread_d;
      memwrite_q <= memwrite_d;
      rdata_q    <= rdata_d;
      err_q      <= err_d;
    end
  end

  // Outputs are decoded straight from registers; writeback never sees a stalled or faulted commit.
  always_comb begin
    stall        = (state_q == BUSY);
    mem_req      = (state_q == BUSY);
    mem_we       = memwrite_q & (state_q == BUSY);
    mem_addr     = alu_q;
    mem_wdata    = wdata_q;
    ALUres_out   = alu_q;
    readData_out = rdata_q;
    rd_out       = rd_q;
    memToReg_out = memtoreg_q;
    memErr       = err_q;
    regWrite_out = regwrite_q & ~(state_q == BUSY) & ~err_q;
  end

endmodule

// File: tb/tb_memory_access.sv
// Directed bench for memory_access: writeback expectations go into a queue at issue
// and are popped when the instruction reaches writeback.
module tb_memory_access;

  logic        clk;
  logic        reset;
  logic [31:0] ALUres, writeData, mem_rdata;
  logic [4:0]  rd;
  logic        regWrite, memToReg, memRead, memWrite, mem_ack;
  logic        mem_req, mem_we, stall, memErr, regWrite_out, memToReg_out;
  logic [31:0] mem_addr, mem_wdata, ALUres_out, readData_out;
  logic [4:0]  rd_out;

  typedef struct packed {
    logic        rw;
    logic [4:0]  rd;
    logic [31:0] alu;
    logic [31:0] rdata;
    logic        err;
    logic        m2r;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  memory_access #(.MAX_WAIT(4)) dut (
    .clk(clk), .reset(reset), .ALUres(ALUres), .writeData(writeData), .rd(rd),
    .regWrite(regWrite), .memToReg(memToReg), .memRead(memRead), .memWrite(memWrite),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .ALUres_out(ALUres_out),
    .readData_out(readData_out), .rd_out(rd_out), .regWrite_out(regWrite_out),
    .memToReg_out(memToReg_out), .stall(stall), .memErr(memErr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic nop_inputs();
    ALUres = 32'd0; writeData = 32'd0; rd = 5'd0;
    regWrite = 1'b0; memToReg = 1'b0; memRead = 1'b0; memWrite = 1'b0;
  endtask

  // Drive one instruction, record its writeback expectation, let it be captured.
  task automatic issue(input logic [31:0] a, input logic [31:0] wd, input logic [4:0] r,
                       input logic rw, input logic m2r, input logic mr, input logic mw,
                       input exp_t e);
    ALUres = a; writeData = wd; rd = r;
    regWrite = rw; memToReg = m2r; memRead = mr; memWrite = mw;
    sb.push_back(e);
    @(posedge clk); #1;
    nop_inputs();
  endtask

  task automatic check_wb(input string tag);
    exp_t e;
    chk({tag, "_sb_has_entry"}, 32'(sb.size() != 0), 32'd1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk({tag, "_stall"},    32'(stall),        32'd0);
      chk({tag, "_regwrite"}, 32'(regWrite_out), 32'(e.rw));
      chk({tag, "_rd"},       32'(rd_out),       32'(e.rd));
      chk({tag, "_alu"},      ALUres_out,        e.alu);
      chk({tag, "_rdata"},    readData_out,      e.rdata);
      chk({tag, "_memerr"},   32'(memErr),       32'(e.err));
      chk({tag, "_memtoreg"}, 32'(memToReg_out), 32'(e.m2r));
    end
  endtask

  initial begin
    int n;
    reset = 1'b1; mem_ack = 1'b0; mem_rdata = 32'd0;
    nop_inputs();
    @(posedge clk); @(posedge clk); #1;
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_memerr", 32'(memErr), 32'd0);
    chk("rst_regwrite", 32'(regWrite_out), 32'd0);
    chk("rst_rdata", readData_out, 32'd0);
    chk("rst_alu", ALUres_out, 32'd0);
    chk("rst_addr", mem_addr, 32'd0);
    reset = 1'b0;

    // ALU op passes straight through
    issue(32'h40, 32'd0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, '{1'b1, 5'd5, 32'h40, 32'd0, 1'b0, 1'b0});
    chk("alu_mem_req", 32'(mem_req), 32'd0);
    check_wb("alu");

    // Load with ack in the third BUSY cycle; upstream inputs change but must be ignored
    issue(32'h100, 32'd0, 5'd7, 1'b1, 1'b1, 1'b1, 1'b0, '{1'b1, 5'd7, 32'h100, 32'hDEADBEEF, 1'b0, 1'b1});
    for (int i = 0; i < 3; i++) begin
      chk("ld_mem_req", 32'(mem_req), 32'd1);
      chk("ld_stall", 32'(stall), 32'd1);
      chk("ld_regwrite_stalled", 32'(regWrite_out), 32'd0);
      chk("ld_mem_we", 32'(mem_we), 32'd0);
      chk("ld_addr", mem_addr, 32'h100);
      ALUres = $urandom; rd = 5'($urandom); regWrite = 1'b1;
      if (i == 2) begin mem_ack = 1'b1; mem_rdata = 32'hDEADBEEF; end
      @(posedge clk); #1;
    end
    mem_ack = 1'b0;
    nop_inputs();
    chk("ld_mem_req_done", 32'(mem_req), 32'd0);
    check_wb("ld");

    // Nop with a stray ack in IDLE: readData must stay 0
    mem_ack = 1'b1; mem_rdata = 32'hFFFF_0000;
    issue(32'h8, 32'd0, 5'd1, 1'b0, 1'b0, 1'b0, 1'b0, '{1'b0, 5'd1, 32'h8, 32'd0, 1'b0, 1'b0});
    mem_ack = 1'b0;
    check_wb("idle_ack");

    // Store with memRead also set: treated as store, readData loads 0
    issue(32'h104, 32'h12345678, 5'd3, 1'b0, 1'b0, 1'b1, 1'b1, '{1'b0, 5'd3, 32'h104, 32'd0, 1'b0, 1'b0});
    for (int i = 0; i < 2; i++) begin
      chk("st_mem_we", 32'(mem_we), 32'd1);
      chk("st_addr", mem_addr, 32'h104);
      chk("st_wdata", mem_wdata, 32'h12345678);
      chk("st_regwrite", 32'(regWrite_out), 32'd0);
      writeData = $urandom;
      if (i == 1) begin mem_ack = 1'b1; mem_rdata = 32'hBAD0BAD0; end
      @(posedge clk); #1;
    end
    mem_ack = 1'b0;
    nop_inputs();
    chk("st_mem_we_done", 32'(mem_we), 32'd0);
    check_wb("st");

    // Load timing out after MAX_WAIT=4 BUSY cycles
    issue(32'h200, 32'd0, 5'd9, 1'b1, 1'b1, 1'b1, 1'b0, '{1'b0, 5'd9, 32'h200, 32'd0, 1'b1, 1'b1});
    n = 0;
    while (mem_req && n < 10) begin
      n++;
      @(posedge clk); #1;
    end
    chk("to_busy_cycles", 32'(n), 32'd4);
    check_wb("to");
    issue(32'h0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, '{1'b0, 5'd0, 32'h0, 32'd0, 1'b0, 1'b0});
    check_wb("to_pulse_end");

    // Ack in the fourth BUSY cycle beats the timeout
    issue(32'h300, 32'd0, 5'd10, 1'b1, 1'b1, 1'b1, 1'b0, '{1'b1, 5'd10, 32'h300, 32'hCAFEF00D, 1'b0, 1'b1});
    for (int i = 0; i < 4; i++) begin
      chk("ack4_mem_req", 32'(mem_req), 32'd1);
      if (i == 3) begin mem_ack = 1'b1; mem_rdata = 32'hCAFEF00D; end
      @(posedge clk); #1;
    end
    mem_ack = 1'b0;
    check_wb("ack4");

    // Misaligned load faults immediately without a request
    issue(32'h102, 32'd0, 5'd11, 1'b1, 1'b1, 1'b1, 1'b0, '{1'b0, 5'd11, 32'h102, 32'd0, 1'b1, 1'b1});
    chk("mis_mem_req", 32'(mem_req), 32'd0);
    check_wb("mis");
    issue(32'h4, 32'd0, 5'd2, 1'b1, 1'b0, 1'b0, 1'b0, '{1'b1, 5'd2, 32'h4, 32'd0, 1'b0, 1'b0});
    chk("mis_after_mem_req", 32'(mem_req), 32'd0);
    check_wb("mis_after");

    // Reset pulse during BUSY cycle 2 clears everything at once
    issue(32'h400, 32'h55, 5'd12, 1'b1, 1'b1, 1'b1, 1'b0, '{1'b1, 5'd12, 32'h400, 32'd0, 1'b0, 1'b1});
    @(posedge clk); #1;
    chk("mid_busy_req", 32'(mem_req), 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("rst2_mem_req", 32'(mem_req), 32'd0);
    chk("rst2_stall", 32'(stall), 32'd0);
    chk("rst2_regwrite", 32'(regWrite_out), 32'd0);
    chk("rst2_alu", ALUres_out, 32'd0);
    chk("rst2_rd", 32'(rd_out), 32'd0);
    chk("rst2_addr", mem_addr, 32'd0);
    chk("rst2_memerr", 32'(memErr), 32'd0);
    sb.delete();
    #2 reset = 1'b0;
    issue(32'h40, 32'd0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, '{1'b1, 5'd5, 32'h40, 32'd0, 1'b0, 1'b0});
    check_wb("post_rst_alu");

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
